load_store_unit: RTL



---
 rtl/load_store_unit.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : CPU load/store initiator for the kernel RAM data port; splits
//            word-crossing accesses and aligns/extends load data.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [31:0]           mem_wdata_out,
  output logic [3:0]            mem_byte_enable,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata_in
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC1   = 3'd1,
    S_ACC2   = 3'd2,
    S_RDWAIT = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] c_SIZE_RSVD = 2'd3;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
  logic [3:0]            r_mem_be,    w_mem_be_nxt;
  logic                  r_mem_write, w_mem_write_nxt;
  logic                  r_resp_valid, w_resp_valid_nxt;
  logic [31:0]           r_resp_rdata, w_resp_rdata_nxt;
  logic                  r_resp_error, w_resp_error_nxt;
  logic [31:0]           r_word1,     w_word1_nxt;

  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [1:0]            r_offset;
  logic                  r_split;
  logic [31:0]           r_hi_wdata;
  logic [3:0]            r_hi_be;

  logic                  w_accept;
  logic [3:0]            w_req_mask;
  logic [7:0]            w_req_be8;
  logic [63:0]           w_req_sh;
  logic                  w_req_split;
  logic [31:0]           w_ld_lo;
  logic [31:0]           w_ld_hi;
  logic [63:0]           w_ld_shift;
  logic [31:0]           w_ld_result;
  logic                  w_unused;

  assign req_ready       = (r_state == S_IDLE);
  assign w_accept        = req_valid && (r_state == S_IDLE);

  assign mem_addr_out    = r_mem_addr;
  assign mem_wdata_out   = r_mem_wdata;
  assign mem_byte_enable = r_mem_be;
  assign mem_write       = r_mem_write;
  assign resp_valid      = r_resp_valid;
  assign resp_rdata      = r_resp_rdata;
  assign resp_error      = r_resp_error;

  always_comb begin
    w_req_mask = 4'b1111;
    case (req_size)
      2'd0:    w_req_mask = 4'b0001;
      2'd1:    w_req_mask = 4'b0011;
      default: w_req_mask = 4'b1111;
    endcase
  end

  // Shifting into a double-width vector yields the first-word lanes in the
  // low half and the spill-over into the next word in the high half.
  assign w_req_be8   = {4'b0000, w_req_mask} << req_addr[1:0];
  assign w_req_sh    = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  assign w_req_split = |w_req_be8[7:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write    <= 1'b0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_offset   <= 2'd0;
      r_split    <= 1'b0;
      r_hi_wdata <= 32'h0;
      r_hi_be    <= 4'h0;
    end else if (w_accept) begin
      r_write    <= req_write;
      r_size     <= req_size;
      r_signed   <= req_signed;
      r_offset   <= req_addr[1:0];
      r_split    <= w_req_split;
      r_hi_wdata <= w_req_sh[63:32];
      r_hi_be    <= w_req_be8[7:4];
    end
  end

  // In RDWAIT the RAM is returning the last word read; for split loads the
  // first word was already captured during ACC2.
  assign w_ld_lo    = r_split ? r_word1 : mem_rdata_in;
  assign w_ld_hi    = r_split ? mem_rdata_in : 32'h0;
  assign w_ld_shift = {w_ld_hi, w_ld_lo} >> {r_offset, 3'b000};

  always_comb begin
    w_ld_result = w_ld_shift[31:0];
    case (r_size)
      2'd0:    w_ld_result = {{24{r_signed & w_ld_shift[7]}},  w_ld_shift[7:0]};
      2'd1:    w_ld_result = {{16{r_signed & w_ld_shift[15]}}, w_ld_shift[15:0]};
      default: w_ld_result = w_ld_shift[31:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0;
      r_mem_be     <= 4'h0;
      r_mem_write  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
      r_word1      <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_error <= w_resp_error_nxt;
      r_word1      <= w_word1_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_be_nxt     = 4'h0;
    w_mem_write_nxt  = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_error_nxt = r_resp_error;
    w_word1_nxt      = r_word1;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_size == c_SIZE_RSVD) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_rdata_nxt = 32'h0;
            w_resp_error_nxt = 1'b1;
          end else begin
            w_state_nxt     = S_ACC1;
            w_mem_addr_nxt  = req_addr[ADDR_WIDTH+1:2];
            w_mem_wdata_nxt = w_req_sh[31:0];
            w_mem_be_nxt    = w_req_be8[3:0];
            w_mem_write_nxt = req_write;
          end
        end
      end

      S_ACC1: begin
        if (r_split) begin
          w_state_nxt     = S_ACC2;
          w_mem_addr_nxt  = r_mem_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          w_mem_wdata_nxt = r_hi_wdata;
          w_mem_be_nxt    = r_hi_be;
          w_mem_write_nxt = r_write;
        end else if (r_write) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = 32'h0;
          w_resp_error_nxt = 1'b0;
        end else begin
          w_state_nxt = S_RDWAIT;
        end
      end

      S_ACC2: begin
        w_word1_nxt = mem_rdata_in;
        if (r_write) begin
          w_state_nxt      = S_RESP;
          w_resp_valid_nxt = 1'b1;
          w_resp_rdata_nxt = 32'h0;
          w_resp_error_nxt = 1'b0;
        end else begin
          w_state_nxt = S_RDWAIT;
        end
      end

      S_RDWAIT: begin
        w_state_nxt      = S_RESP;
        w_resp_valid_nxt = 1'b1;
        w_resp_rdata_nxt = w_ld_result;
        w_resp_error_nxt = 1'b0;
      end

      S_RESP: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_unused = ^{req_addr[31:ADDR_WIDTH+2], w_ld_shift[63:32]};

endmodule
`default_nettype wire
